// File: rtl/fir_tap_sequencer_pkg.sv
// FIR tap sequencer shared types: controller state encoding and accumulator sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    READ,
    DRAIN,
    OUT
  } state_t;

  // Width that holds the sum of 2**aw full-precision products without overflow.
  function automatic int acc_width(input int dw, input int cw, input int aw);
    return dw + cw + aw;
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Bundles the sample handshake, filter output and both memory ports of the tap sequencer.
// Latency: n/a (wires only).
// Backpressure: ready_o/sample_valid_i handshake; memory ports carry no flow control.
// Ports: master = sequencer side, slave = sample source plus delay-line RAM and coefficient memory.
interface fir_tap_sequencer_if
  import fir_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int CWIDTH = 16,
  parameter int AWIDTH = 9
);
  localparam int ACCW = acc_width(DWIDTH, CWIDTH, AWIDTH);

  logic [DWIDTH-1:0] sample_i;
  logic              sample_valid_i;
  logic              ready_o;
  logic [ACCW-1:0]   y_o;
  logic              y_valid_o;
  logic [DWIDTH-1:0] ram_wrdata_o;
  logic [AWIDTH-1:0] ram_wraddr_o;
  logic              ram_wren_o;
  logic [AWIDTH-1:0] ram_rdaddr_o;
  logic [DWIDTH-1:0] ram_rddata_i;
  logic [AWIDTH-1:0] coef_rdaddr_o;
  logic [CWIDTH-1:0] coef_rddata_i;

  modport master (
    input  sample_i, sample_valid_i, ram_rddata_i, coef_rddata_i,
    output ready_o, y_o, y_valid_o, ram_wrdata_o, ram_wraddr_o, ram_wren_o,
           ram_rdaddr_o, coef_rdaddr_o
  );

  modport slave (
    output sample_i, sample_valid_i, ram_rddata_i, coef_rddata_i,
    input  ready_o, y_o, y_valid_o, ram_wrdata_o, ram_wraddr_o, ram_wren_o,
           ram_rdaddr_o, coef_rdaddr_o
  );

endinterface

// File: rtl/fir_tap_sequencer_mac.sv
// Signed multiply-accumulate: acc += sext(a*b) when enabled, acc = 0 on clear.
// Latency: 1 cycle into the accumulator; o_acc_nxt is the combinational next sum.
// Backpressure: none; i_en qualifies every operand pair.
// Ports: clk_i/rst_i, i_clr, i_en, i_a (sample), i_b (coef), o_acc_nxt (r_acc + product).
module fir_mac #(
  parameter int DWIDTH = 16,
  parameter int CWIDTH = 16,
  parameter int ACCW   = 41
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DWIDTH-1:0] i_a,
  input  logic signed [CWIDTH-1:0] i_b,
  output logic signed [ACCW-1:0]   o_acc_nxt
);
  localparam int PW = DWIDTH + CWIDTH;

  logic signed [PW-1:0]   w_prod;
  logic signed [ACCW-1:0] w_prod_ext;
  logic signed [ACCW-1:0] r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(ACCW-PW){w_prod[PW-1]}}, w_prod};
  assign o_acc_nxt  = r_acc + w_prod_ext;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_acc_nxt;
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR control + MAC: writes each accepted sample into the circular delay line, walks TAPS taps newest-first, emits one sum.
// Latency: accept to y_valid_o = TAPS+2 cycles; after reset the delay line is zeroed for 2**AWIDTH cycles first.
// Backpressure: ready_o only in IDLE/OUT; sample_valid_i ignored otherwise; one sample per TAPS+2 cycles at best.
// Ports: clk_i, rst_i (async, active-high), bus (master modport: sample handshake, y output, RAM and coef ports).
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int CWIDTH = 16,
  parameter int AWIDTH = 9,
  parameter int TAPS   = 512
) (
  input  logic                clk_i,
  input  logic                rst_i,
  fir_tap_sequencer_if.master bus
);
  localparam int ACCW = acc_width(DWIDTH, CWIDTH, AWIDTH);
  localparam logic [AWIDTH-1:0] LAST_K  = AWIDTH'(TAPS - 1);
  localparam logic [AWIDTH-1:0] CLR_END = '1;

  state_t r_state, w_state_nxt;

  logic [AWIDTH-1:0]      r_clr_cnt;
  logic [AWIDTH-1:0]      r_wr_ptr;
  logic [AWIDTH-1:0]      r_base;
  logic [AWIDTH-1:0]      r_k;
  logic                   r_dv;
  logic [ACCW-1:0]        r_y;
  logic                   w_accept;
  logic signed [ACCW-1:0] w_acc_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_accept          = 1'b0;
    bus.ready_o       = 1'b0;
    bus.y_valid_o     = 1'b0;
    bus.y_o           = r_y;
    bus.ram_wren_o    = 1'b0;
    bus.ram_wrdata_o  = '0;
    bus.ram_wraddr_o  = r_wr_ptr;
    bus.ram_rdaddr_o  = '0;
    bus.coef_rdaddr_o = '0;
    case (r_state)
      CLEAR: begin
        // Gate with reset so nothing is written while reset is held.
        bus.ram_wren_o   = !rst_i;
        bus.ram_wraddr_o = r_clr_cnt;
        if (r_clr_cnt == CLR_END) begin
          w_state_nxt = IDLE;
        end
      end
      IDLE, OUT: begin
        // OUT doubles as an accept slot so back-to-back samples lose no cycle.
        bus.ready_o   = 1'b1;
        bus.y_valid_o = (r_state == OUT);
        w_accept      = bus.sample_valid_i;
        if (w_accept) begin
          bus.ram_wren_o   = 1'b1;
          bus.ram_wrdata_o = bus.sample_i;
          w_state_nxt      = READ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      READ: begin
        // Newest-first walk; AWIDTH-bit subtraction wraps around the circular buffer.
        bus.ram_rdaddr_o  = r_base - r_k;
        bus.coef_rdaddr_o = r_k;
        if (r_k == LAST_K) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_state_nxt = OUT;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_clr_cnt <= '0;
      r_wr_ptr  <= '0;
      r_base    <= '0;
      r_k       <= '0;
      r_dv      <= 1'b0;
      r_y       <= '0;
    end else begin
      // Memory read data lags its address by one cycle.
      r_dv <= (r_state == READ);
      if (r_state == CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
      if (w_accept) begin
        r_base   <= r_wr_ptr;
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_k      <= '0;
      end else if (r_state == READ) begin
        r_k <= r_k + 1'b1;
      end
      // DRAIN carries the last product; capture the completed sum for OUT.
      if (r_state == DRAIN) begin
        r_y <= w_acc_nxt;
      end
    end
  end

  fir_mac #(
    .DWIDTH(DWIDTH),
    .CWIDTH(CWIDTH),
    .ACCW  (ACCW)
  ) u_mac (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_clr    (w_accept),
    .i_en     (r_dv),
    .i_a      ($signed(bus.ram_rddata_i)),
    .i_b      ($signed(bus.coef_rddata_i)),
    .o_acc_nxt(w_acc_nxt)
  );

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer with TAPS=4, AWIDTH=3; behavioural 1-cycle RAM and coefficient memory.
// Driver pushes hand-computed expected outputs with their accept cycle; a forked monitor pops on y_valid_o.
// Ports: none (top-level bench).
module tb_fir_tap_sequencer;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = 3;
  localparam int TP = 4;
  localparam int LAT = TP + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;

  longint exp_q[$];
  int     acc_q[$];

  logic [DW-1:0]        ram  [8];
  logic signed [CW-1:0] coef [8];

  fir_tap_sequencer_if #(.DWIDTH(DW), .CWIDTH(CW), .AWIDTH(AW)) bus ();

  fir_tap_sequencer #(.DWIDTH(DW), .CWIDTH(CW), .AWIDTH(AW), .TAPS(TP)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.ram_wren_o) ram[bus.ram_wraddr_o] <= bus.ram_wrdata_o;
    bus.ram_rddata_i  <= ram[bus.ram_rdaddr_o];
    bus.coef_rddata_i <= coef[bus.coef_rdaddr_o];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_tot++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  task automatic monitor();
    longint e;
    int a;
    forever begin
      @(negedge clk);
      if (bus.y_valid_o) begin
        if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_y: got y=%0d expected no output", $signed(bus.y_o));
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("y_value", longint'($signed(bus.y_o)), e);
          chk("latency", longint'(cyc - a), LAT);
        end
      end
    end
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
    for (int i = 0; i < 8; i++) coef[i] = '0;
    coef[0] = CW'(c0); coef[1] = CW'(c1); coef[2] = CW'(c2); coef[3] = CW'(c3);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
  task automatic send(input logic signed [DW-1:0] d, input longint e, input bit push);
    int w = 0;
    bus.sample_i       = d;
    bus.sample_valid_i = 1'b1;
    while (!bus.ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ready_o) begin
      fail_now("send_timeout");
    end else begin
      if (w > 0) chk("b2b_accept_in_out", longint'(bus.y_valid_o), 1);
      if (push) begin
        exp_q.push_back(e);
        acc_q.push_back(cyc);
      end
    end
    @(negedge clk);
  endtask

  task automatic drop();
    bus.sample_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(negedge clk);
    @(negedge clk);
  endtask

  // Reset is released just after a posedge; each following negedge sees one CLEAR address.
  task automatic check_clear();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("clear_ready", longint'(bus.ready_o), 0);
      chk("clear_wren", longint'(bus.ram_wren_o), 1);
      chk("clear_wraddr", longint'(bus.ram_wraddr_o), i);
      chk("clear_wrdata", longint'(bus.ram_wrdata_o), 0);
    end
    @(negedge clk);
    chk("ready_after_clear", longint'(bus.ready_o), 1);
  endtask

  task automatic impulse();
    set_coefs(1, 2, 3, 4);
    send(16'sd100, 100, 1'b1);
    send(16'sd0, 200, 1'b1);
    send(16'sd0, 300, 1'b1);
    send(16'sd0, 400, 1'b1);
    send(16'sd0, 0, 1'b1);
    drop();
    wait_drain();
  endtask

  initial begin
    bus.sample_i       = '0;
    bus.sample_valid_i = 1'b0;
    set_coefs(1, 2, 3, 4);
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", longint'(bus.ready_o), 0);
    chk("rst_y_valid", longint'(bus.y_valid_o), 0);
    chk("rst_y", longint'($signed(bus.y_o)), 0);
    chk("rst_wren", longint'(bus.ram_wren_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_clear();

    // Impulse response walks the coefficients.
    impulse();

    // Moving sum of four, wr_ptr wraps 7->0 mid-run; valid held high throughout.
    set_coefs(1, 1, 1, 1);
    for (int i = 0; i < 12; i++) send(16'sd1, (i < 4) ? longint'(i + 1) : 64'sd4, 1'b1);
    drop();
    wait_drain();

    // Extremes: history is all ones before these.
    set_coefs(-32768, -32768, -32768, -32768);
    send(16'sh8000, 64'sd1073643520, 1'b1);
    send(16'sh8000, 64'sd2147418112, 1'b1);
    send(16'sh8000, 64'sd3221192704, 1'b1);
    send(16'sh8000, 64'sd4294967296, 1'b1);
    send(16'sd32767, 64'sd2147516416, 1'b1);
    drop();
    wait_drain();

    // Busy ignore: 55 offered during READ must not be written or accepted.
    set_coefs(1, 2, 3, 4);
    send(16'sd10, -64'sd163832, 1'b1);
    bus.sample_i       = 16'sd55;
    bus.sample_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("busy_ready", longint'(bus.ready_o), 0);
      chk("busy_wren", longint'(bus.ram_wren_o), 0);
      @(negedge clk);
    end
    drop();
    send(16'sd0, -64'sd32751, 1'b1);
    drop();
    wait_drain();

    // Reset in cycle 2 of a READ: no output, re-clear, then a clean impulse.
    send(16'sd77, 0, 1'b0);
    drop();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ready", longint'(bus.ready_o), 0);
    chk("midrst_y_valid", longint'(bus.y_valid_o), 0);
    chk("midrst_y", longint'($signed(bus.y_o)), 0);
    chk("midrst_wren", longint'(bus.ram_wren_o), 0);
    chk("midrst_rdaddr", longint'(bus.ram_rdaddr_o), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_clear();
    impulse();

    repeat (10) @(negedge clk);
    chk("leftover_expected", longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
